// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl: single-outstanding memory slave in front of an external
// asynchronous 32-bit SRAM. Requests are accepted only when idle, decoded
// against the SRAM address window and then run for WAIT_CYCLES+1 cycles on
// the SRAM pins. Read data, a write acknowledge or an out-of-window error
// comes back on a valid/ready response channel. Every output is a flop so
// the pads see glitch-free strobes.
module mem_sram_ctrl #(
  parameter logic [31:0] BASE        = 32'h8000_0000,
  parameter int          SRAM_AW     = 20,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [31:0]        req_addr,
  input  logic               req_we,
  input  logic [3:0]         req_be,
  input  logic [31:0]        req_wdata,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [31:0]        resp_rdata,
  output logic               resp_err,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [31:0]        sram_dq_in,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic [3:0]         sram_be_n
);

  // Counter wide enough to hold WAIT_CYCLES down to zero.
  localparam int CW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // The write-hold cycle needs at least one strobe cycle before it, and the
  // SRAM is word addressed, so both parameters are checked at elaboration.
  if (WAIT_CYCLES < 1) begin : g_bad_wait
    $error("mem_sram_ctrl: WAIT_CYCLES must be >= 1");
  end
  if (BASE[1:0] != 2'b00) begin : g_bad_base
    $error("mem_sram_ctrl: BASE must be 4-byte aligned");
  end

  // Expand the four byte enables into a 32-bit lane mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    m = 32'd0;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

  state_t          state_r;
  state_t          state_nxt_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_nxt_s;
  logic            we_r;
  logic            we_nxt_s;
  logic [3:0]      be_r;
  logic [3:0]      be_nxt_s;

  logic [31:0]        off_s;
  logic               in_win_s;
  logic               fire_s;

  logic               req_ready_nxt_s;
  logic               resp_valid_nxt_s;
  logic [31:0]        resp_rdata_nxt_s;
  logic               resp_err_nxt_s;
  logic [SRAM_AW-1:0] sram_addr_nxt_s;
  logic [31:0]        sram_dq_out_nxt_s;
  logic               sram_dq_oe_nxt_s;
  logic               sram_ce_n_nxt_s;
  logic               sram_oe_n_nxt_s;
  logic               sram_we_n_nxt_s;
  logic [3:0]         sram_be_n_nxt_s;

  // Window decode. The lower-bound test stops a wrapped offset (address
  // below BASE) from aliasing into the window; a shift of 32 or more yields 0.
  always_comb begin
    off_s    = req_addr - BASE;
    in_win_s = (req_addr >= BASE) && ((off_s >> (SRAM_AW + 2)) == 32'd0);
    fire_s   = req_valid && req_ready;
  end

  // Next-state, latched request fields and next values of every output flop.
  always_comb begin
    state_nxt_s       = state_r;
    cnt_nxt_s         = cnt_r;
    we_nxt_s          = we_r;
    be_nxt_s          = be_r;
    resp_rdata_nxt_s  = resp_rdata;
    resp_err_nxt_s    = resp_err;
    sram_addr_nxt_s   = sram_addr;
    sram_dq_out_nxt_s = sram_dq_out;

    case (state_r)
      ST_IDLE: begin
        if (fire_s) begin
          we_nxt_s = req_we;
          be_nxt_s = req_be;
          if (in_win_s) begin
            state_nxt_s     = ST_ACCESS;
            cnt_nxt_s       = CW'(WAIT_CYCLES);
            sram_addr_nxt_s = off_s[SRAM_AW+1:2];
            if (req_we) begin
              sram_dq_out_nxt_s = req_wdata;
            end else begin
              sram_dq_out_nxt_s = sram_dq_out;
            end
          end else begin
            state_nxt_s      = ST_RESP;
            resp_err_nxt_s   = 1'b1;
            resp_rdata_nxt_s = 32'd0;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (cnt_r == CW'(1'b0)) begin
          state_nxt_s    = ST_RESP;
          resp_err_nxt_s = 1'b0;
          if (we_r) begin
            resp_rdata_nxt_s = 32'd0;
          end else begin
            resp_rdata_nxt_s = sram_dq_in & lane_mask(be_r);
          end
        end else begin
          cnt_nxt_s = cnt_r - CW'(1'b1);
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    // Pin strobes follow the state being entered so they are registered.
    // we_n rises for the last ACCESS cycle to hold address/data past it.
    req_ready_nxt_s  = (state_nxt_s == ST_IDLE);
    resp_valid_nxt_s = (state_nxt_s == ST_RESP);
    sram_ce_n_nxt_s  = (state_nxt_s != ST_ACCESS);
    sram_oe_n_nxt_s  = !((state_nxt_s == ST_ACCESS) && !we_nxt_s);
    sram_we_n_nxt_s  = !((state_nxt_s == ST_ACCESS) && we_nxt_s &&
                         (cnt_nxt_s != CW'(1'b0)));
    sram_dq_oe_nxt_s = (state_nxt_s == ST_ACCESS) && we_nxt_s;
    if (state_nxt_s == ST_ACCESS) begin
      sram_be_n_nxt_s = ~be_nxt_s;
    end else begin
      sram_be_n_nxt_s = 4'hF;
    end
  end

  // FSM state, wait counter and latched request attributes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= CW'(1'b0);
      we_r    <= 1'b0;
      be_r    <= 4'h0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      we_r    <= we_nxt_s;
      be_r    <= be_nxt_s;
    end
  end

  // Output flops; reset drops every strobe and the pad enable immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_rdata  <= 32'd0;
      resp_err    <= 1'b0;
      sram_addr   <= {SRAM_AW{1'b0}};
      sram_dq_out <= 32'd0;
      sram_dq_oe  <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      sram_be_n   <= 4'hF;
    end else begin
      req_ready   <= req_ready_nxt_s;
      resp_valid  <= resp_valid_nxt_s;
      resp_rdata  <= resp_rdata_nxt_s;
      resp_err    <= resp_err_nxt_s;
      sram_addr   <= sram_addr_nxt_s;
      sram_dq_out <= sram_dq_out_nxt_s;
      sram_dq_oe  <= sram_dq_oe_nxt_s;
      sram_ce_n   <= sram_ce_n_nxt_s;
      sram_oe_n   <= sram_oe_n_nxt_s;
      sram_we_n   <= sram_we_n_nxt_s;
      sram_be_n   <= sram_be_n_nxt_s;
    end
  end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Scoreboard bench for mem_sram_ctrl: the stimulus side computes each
// expected response from a word-array reference memory and pushes it; a
// monitor pops and compares whenever a response is presented. A separate
// behavioural SRAM model answers the pins.
module tb_mem_sram_ctrl;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int AW = 20;
  localparam int W  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [31:0]   req_addr = 32'd0;
  logic          req_we = 1'b0;
  logic [3:0]    req_be = 4'h0;
  logic [31:0]   req_wdata = 32'd0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_dq_out;
  logic          sram_dq_oe;
  logic [31:0]   sram_dq_in = 32'd0;
  logic          sram_ce_n;
  logic          sram_oe_n;
  logic          sram_we_n;
  logic [3:0]    sram_be_n;

  mem_sram_ctrl #(.BASE(BASE), .SRAM_AW(AW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_be(req_be), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_hs = -100;
  bit bp = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  typedef struct {
    logic [31:0]   rdata;
    logic          err;
    int            due;
    int            ce;
    int            we;
    int            oe;
    int            dqoe;
    logic [AW-1:0] addr;
    logic [3:0]    be_n;
    logic [31:0]   wdata;
  } exp_t;

  exp_t sb[$];
  logic [31:0] sram_mem[int];
  logic [31:0] ref_mem[int];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int idx);
    logic [31:0] t;
    t = idx;
    return (t * 32'h9E37_79B9) + 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] ref_rd(input int idx);
    if (ref_mem.exists(idx)) return ref_mem[idx];
    return init_word(idx);
  endfunction

  function automatic logic [31:0] sram_rd(input int idx);
    if (sram_mem.exists(idx)) return sram_mem[idx];
    return init_word(idx);
  endfunction

  function automatic logic [31:0] lanes(input logic [3:0] be);
    logic [31:0] m;
    m = 32'd0;
    for (int i = 0; i < 4; i++) if (be[i]) m = m | (32'h0000_00FF << (8 * i));
    return m;
  endfunction

  task automatic preload(input int idx, input logic [31:0] v);
    sram_mem[idx] = v;
    ref_mem[idx]  = v;
  endtask

  // Present one request, wait for acceptance and push its expected outcome.
  task automatic issue(input logic [31:0] addr, input logic we, input logic [3:0] be,
                       input logic [31:0] wd, output int fire_cyc);
    exp_t    e;
    longint  a;
    longint  lo;
    longint  hi;
    bit      inwin;
    bit      fired;
    int      idx;
    logic [31:0] w;
    req_addr  = addr;
    req_we    = we;
    req_be    = be;
    req_wdata = wd;
    req_valid = 1'b1;
    fired = 1'b0;
    for (int k = 0; k < 60 && !fired; k++) begin
      @(negedge clk);
      if (req_ready) fired = 1'b1;
    end
    if (!fired) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout: request %h never accepted", addr);
      req_valid = 1'b0;
      fire_cyc = -1;
      return;
    end
    fire_cyc = cyc;
    a  = addr;
    lo = BASE;
    hi = lo + (longint'(4) << AW);
    inwin = (a >= lo) && (a < hi);
    idx = inwin ? int'((a - lo) >> 2) : 0;
    e.addr  = idx[AW-1:0];
    e.be_n  = ~be;
    e.wdata = wd;
    if (!inwin) begin
      e.rdata = 32'd0; e.err = 1'b1; e.due = fire_cyc + 1;
      e.ce = 0; e.we = 0; e.oe = 0; e.dqoe = 0;
    end else begin
      e.err = 1'b0; e.due = fire_cyc + W + 2; e.ce = W + 1;
      if (we) begin
        w = ref_rd(idx);
        for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
        ref_mem[idx] = w;
        e.rdata = 32'd0; e.we = W; e.oe = 0; e.dqoe = W + 1;
      end else begin
        e.rdata = ref_rd(idx) & lanes(be); e.we = 0; e.oe = W + 1; e.dqoe = 0;
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && sb.size() != 0; k++) @(negedge clk);
    chk("drain_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Behavioural asynchronous SRAM: writes lanes while we_n is low, drives
  // stored data while oe_n is low and junk otherwise.
  initial forever begin
    logic [31:0] w;
    @(negedge clk);
    if (!rst && !sram_ce_n && !sram_we_n) begin
      w = sram_rd(int'(sram_addr));
      for (int i = 0; i < 4; i++) if (!sram_be_n[i]) w[8*i +: 8] = sram_dq_out[8*i +: 8];
      sram_mem[int'(sram_addr)] = w;
    end
    if (!sram_ce_n && !sram_oe_n) sram_dq_in = sram_rd(int'(sram_addr));
    else sram_dq_in = $urandom;
  end

  // Random response back-pressure.
  initial forever begin
    @(posedge clk);
    #1;
    if (bp) resp_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: strobe accounting, response checking and scoreboard pops.
  int ce_c = 0, we_c = 0, oe_c = 0, dqoe_c = 0;
  bit seen = 1'b0;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      sb.delete();
      ce_c = 0; we_c = 0; oe_c = 0; dqoe_c = 0; seen = 1'b0;
    end else begin
      if (!sram_ce_n) begin
        ce_c++;
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL stray_ce: ce_n low with no request outstanding");
        end else begin
          chk("sram_addr", 32'(sram_addr), 32'(sb[0].addr));
          chk("sram_be_n", 32'(sram_be_n), 32'(sb[0].be_n));
        end
      end
      if (!sram_we_n) we_c++;
      if (!sram_oe_n) oe_c++;
      if (sram_dq_oe) begin
        dqoe_c++;
        if (sb.size() != 0) chk("sram_dq_out", sram_dq_out, sb[0].wdata);
      end
      if (resp_valid) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_resp: rdata %h err %b", resp_rdata, resp_err);
        end else begin
          if (!seen) begin
            seen = 1'b1;
            chk("resp_latency", cyc, sb[0].due);
            chk("ce_low_cycles", ce_c, sb[0].ce);
            chk("we_low_cycles", we_c, sb[0].we);
            chk("oe_low_cycles", oe_c, sb[0].oe);
            chk("dq_oe_cycles", dqoe_c, sb[0].dqoe);
          end
          chk("resp_rdata", resp_rdata, sb[0].rdata);
          chk("resp_err", 32'(resp_err), 32'(sb[0].err));
          chk("req_ready_busy", 32'(req_ready), 32'd0);
          chk("ce_n_in_resp", 32'(sram_ce_n), 32'd1);
          if (resp_ready) begin
            void'(sb.pop_front());
            seen = 1'b0;
            ce_c = 0; we_c = 0; oe_c = 0; dqoe_c = 0;
            last_hs = cyc;
          end
        end
      end else if (sb.size() == 0) begin
        chk("idle_req_ready", 32'(req_ready), 32'd1);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fc;
    int fcb;
    int r;
    logic [31:0] addr;
    bit wr;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_strobes", {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd7);
    chk("rst_be_n", 32'(sram_be_n), 32'hF);
    chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_sram_addr", 32'(sram_addr), 32'd0);
    chk("rst_dq_out", sram_dq_out, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic read, partial write with read-back, window edges.
    preload(4, 32'hDEAD_BEEF);
    issue(32'h8000_0010, 1'b0, 4'hF, 32'd0, fc);
    issue(32'h8000_0004, 1'b1, 4'h3, 32'h1234_5678, fc);
    issue(32'h8000_0004, 1'b0, 4'hF, 32'd0, fc);
    issue(32'h7FFF_FFFC, 1'b0, 4'hF, 32'd0, fc);
    issue(32'h8040_0000, 1'b0, 4'hF, 32'd0, fc);
    issue(32'h803F_FFFC, 1'b0, 4'hF, 32'd0, fc);
    issue(32'h0000_0010, 1'b0, 4'hF, 32'd0, fc);
    issue(32'h8000_0023, 1'b0, 4'h0, 32'd0, fc);
    drain();

    // Response stall with the next request already waiting.
    resp_ready = 1'b0;
    issue(32'h8000_0008, 1'b0, 4'hF, 32'd0, fc);
    fork
      issue(32'h8000_000C, 1'b0, 4'hF, 32'd0, fcb);
      begin
        for (int k = 0; k < 40 && !resp_valid; k++) @(negedge clk);
        repeat (5) begin
          @(negedge clk);
          chk("stall_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
      end
    join
    chk("accept_after_resp", fcb, last_hs + 1);
    drain();

    // Reset during the second ACCESS cycle of a write.
    issue(BASE + 32'd4000, 1'b1, 4'hF, 32'hCAFE_F00D, fc);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_strobes", {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd7);
    chk("rst_mid_dq_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_mid_be_n", 32'(sram_be_n), 32'hF);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    chk("post_rst_no_resp", 32'(resp_valid), 32'd0);
    @(posedge clk);
    #1;
    preload(8, 32'hAABB_CCDD);
    issue(32'h8000_0020, 1'b0, 4'h5, 32'd0, fc);
    issue(32'h8000_0020, 1'b0, 4'hF, 32'd0, fc);
    drain();

    // Randomized traffic with back-pressure.
    bp = 1'b1;
    for (int t = 0; t < 150; t++) begin
      r = $urandom_range(0, 9);
      if (r <= 5)      addr = BASE + (32'($urandom_range(0, 31)) << 2) + 32'($urandom_range(0, 3));
      else if (r == 6) addr = BASE + ((32'(1 << AW) - 32'd1 - 32'($urandom_range(0, 3))) << 2);
      else if (r == 7) addr = BASE - (32'd4 * 32'($urandom_range(1, 4)));
      else if (r == 8) addr = BASE + (32'd4 << AW) + (32'd4 * 32'($urandom_range(0, 3)));
      else             addr = $urandom;
      wr = $urandom_range(0, 1) != 0;
      issue(addr, wr, 4'($urandom_range(0, 15)), $urandom, fc);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    bp = 1'b0;
    @(posedge clk);
    #2;
    resp_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_sram_ctrl.md
Name: mem_sram_ctrl

Overview:
Memory slave that sits directly downstream of the CPU core's external memory request/response handshake. It accepts one request at a time and drives an external asynchronous single-port 32-bit SRAM with a fixed number of wait states. It returns read data, or a write acknowledge, through a valid/ready response channel. Out-of-window addresses complete with an error response and no SRAM activity.

Parameters:
BASE, 'h80000000, byte address of SRAM word 0; must be 4-byte aligned.
SRAM_AW, 20, SRAM word-address width; the window is 4*2^SRAM_AW bytes.
WAIT_CYCLES, 2, extra ACCESS cycles per transfer; must be >= 1 (elaboration assertion).

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  request valid
req_ready  out  1  request ready
req_addr  in  32  byte address
req_we  in  1  1 = write, 0 = read
req_be  in  4  byte enables (bit i = bits 8i+7:8i)
req_wdata  in  32  write data
resp_valid  out  1  response valid
resp_ready  in  1  response ready
resp_rdata  out  32  read data (0 for writes and errors)
resp_err  out  1  address outside window
sram_addr  out  SRAM_AW  word address
sram_dq_out  out  32  write data to the pad
sram_dq_oe  out  1  pad output enable
sram_dq_in  in  32  read data from the pad
sram_ce_n  out  1  chip enable, active-low
sram_oe_n  out  1  output enable, active-low
sram_we_n  out  1  write enable, active-low
sram_be_n  out  4  byte lanes, active-low

Behaviour:
- Reset values: state IDLE; req_ready = 1; resp_valid = 0; resp_rdata = 0; resp_err = 0; sram_ce_n, sram_oe_n, sram_we_n = 1; sram_be_n = 4'hF; sram_dq_oe = 0; sram_addr = 0; sram_dq_out = 0.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready = 1 only in IDLE; a request fires on req_valid && req_ready.
  - On a fire, latch addr, we, be and wdata.
  - Compute off = req_addr - BASE (32-bit, wrapping). The request is in window iff req_addr >= BASE and off[31:SRAM_AW+2] == 0.
  - In window: go to ACCESS with cnt = WAIT_CYCLES and sram_addr = off[SRAM_AW+1:2]. req_addr[1:0] is ignored.
  - Out of window: go directly to RESP with resp_err = 1 and resp_rdata = 0. No SRAM strobe is asserted.
- ACCESS (WAIT_CYCLES+1 cycles; cnt decrements each cycle):
  - sram_ce_n = 0 and sram_be_n = ~be for the whole state.
  - Read: sram_oe_n = 0 throughout. sram_dq_in is captured into resp_rdata on the clock edge leaving ACCESS (cnt == 0). Bytes with be = 0 are zeroed.
  - Write: sram_dq_oe = 1 and sram_dq_out = wdata throughout. sram_we_n = 0 while cnt != 0, and 1 in the final cycle (address/data hold). resp_rdata = 0.
  - cnt == 0: go to RESP with resp_err = 0.
- RESP:
  - resp_valid = 1. resp_rdata and resp_err are held stable until resp_ready.
  - All SRAM strobes are deasserted and sram_dq_oe = 0.
  - On resp_valid && resp_ready, go to IDLE. req_ready rises the following cycle (no same-cycle bypass).
- Latency:
  - In-window request fired in cycle N: resp_valid is first high in cycle N+WAIT_CYCLES+2.
  - Error request fired in cycle N: resp_valid is first high in cycle N+1.
  - Peak throughput: one transfer per WAIT_CYCLES+3 cycles.
- Only one transfer is outstanding. New request inputs are ignored outside IDLE.
- be = 0 in window: normal ACCESS timing with all lanes disabled; a read returns 0.
- Reset asserted mid-transfer: all strobes deassert and dq_oe drops asynchronously. The pending response is discarded.
- Window edges: BASE + 4*2^SRAM_AW - 4 is the last valid word. BASE + 4*2^SRAM_AW and BASE - 4 return an error. Wrap-around in off must not alias into the window.

Test Plan:
- Read at 'h80000010, sram_dq_in = 'hDEADBEEF, be = 'hF, WAIT_CYCLES = 2, resp_ready = 1 -> sram_addr = 4; oe_n low for 3 cycles; resp_valid high 4 cycles after fire; resp_rdata = 'hDEADBEEF; resp_err = 0.
- Write 'h12345678 at 'h80000004, be = 'h3 -> sram_addr = 1, be_n = 'hC; we_n low for exactly 2 cycles, then 1 hold cycle with ce_n low; dq_oe high for 3 cycles; resp_rdata = 0.
- Read at 'h7FFFFFFC and at 'h80400000 (SRAM_AW = 20) -> resp_err = 1 one cycle after each fire; ce_n never low. Read at 'h803FFFFC -> sram_addr = 'hFFFFF, resp_err = 0.
- Hold resp_ready = 0 for 5 cycles after resp_valid while req_valid stays high -> resp_rdata/resp_err stable; req_ready = 0 throughout; next request accepted the cycle after resp_ready goes high.
- Assert rst during the second ACCESS cycle of a write -> we_n, ce_n = 1 and dq_oe = 0 immediately; no response produced; after release, req_ready = 1 and a fresh read completes normally.
- Read with be = 'h5, sram_dq_in = 'hAABBCCDD -> resp_rdata = 'h00BB00DD.
